// File: rtl/rx_frame_controller.sv
// rx_frame_controller: SOF-driven frame acquisition/tracking with flywheel ride-through.
// Optional frame statistics counters are built when RX_FRAME_STATS_EN is defined.
module rx_frame_controller #(
  parameter int FRAME_SYMS   = 63,
  parameter int VERIFY_COUNT = 2,
  parameter int MISS_LIMIT   = 3,
  parameter int GAP_TIMEOUT  = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof_pulse,
  input  logic        sym_valid,
  input  logic [1:0]  sym_data,
  output logic        out_valid,
  output logic [1:0]  out_data,
  output logic        frame_start,
  output logic        frame_end,
  output logic        locked,
  output logic [1:0]  state,
  output logic        sof_spurious,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_lost
);
  localparam int IW = $clog2(FRAME_SYMS);
  localparam int TW = $clog2(GAP_TIMEOUT);
  localparam int HW = $clog2(VERIFY_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED, FLYWHEEL} state_t;
  state_t st;
  logic gap;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmr;
  logic [HW-1:0] hits;
  logic [MW-1:0] misses, miss_n;
  logic trk, last_sym, tmo, fwd;
  assign trk      = st == LOCKED || st == FLYWHEEL;
  assign last_sym = idx == IW'(FRAME_SYMS - 1);
  assign tmo      = tmr == TW'(GAP_TIMEOUT - 1);
  assign fwd      = trk && !gap && sym_valid;
  assign miss_n   = st == LOCKED ? MW'(1) : misses + MW'(1);
  assign locked   = trk;
  assign state    = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st           <= HUNT;
      gap          <= 1'b0;
      idx          <= '0;
      tmr          <= '0;
      hits         <= '0;
      misses       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      sof_spurious <= 1'b0;
    end else begin
      out_valid    <= fwd;
      out_data     <= fwd ? sym_data : '0;
      frame_start  <= fwd && idx == '0;
      frame_end    <= fwd && last_sym;
      sof_spurious <= trk && !gap && sof_pulse;
      if (st == HUNT) begin
        if (sof_pulse) begin
          st   <= VERIFY;
          gap  <= 1'b0;
          idx  <= '0;
          hits <= '0;
        end
      end else if (!gap) begin
        // a SOF inside a VERIFY payload means our candidate timing was wrong
        if (st == VERIFY && sof_pulse) begin
          idx  <= '0;
          hits <= '0;
        end else if (sym_valid) begin
          gap <= last_sym;
          idx <= last_sym ? idx : idx + IW'(1);
          tmr <= '0;
        end
      end else if (sof_pulse) begin
        gap    <= 1'b0;
        idx    <= '0;
        misses <= '0;
        hits   <= st == VERIFY ? hits + HW'(1) : hits;
        st     <= (st == VERIFY && hits != HW'(VERIFY_COUNT - 1)) ? VERIFY : LOCKED;
      end else if (tmo) begin
        gap    <= 1'b0;
        idx    <= '0;
        misses <= st == VERIFY ? misses : miss_n;
        st     <= (st == VERIFY || miss_n == MW'(MISS_LIMIT)) ? HUNT : FLYWHEEL;
      end else
        tmr <= tmr + TW'(1);
    end
`ifdef RX_FRAME_STATS_EN
  logic hit_trk, miss_trk;
  assign hit_trk  = trk && gap && sof_pulse;
  assign miss_trk = trk && gap && !sof_pulse && tmo;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frames_ok   <= '0;
      frames_lost <= '0;
    end else begin
      frames_ok   <= (hit_trk && frames_ok != 16'hFFFF) ? frames_ok + 16'd1 : frames_ok;
      frames_lost <= (miss_trk && frames_lost != 16'hFFFF) ? frames_lost + 16'd1 : frames_lost;
    end
`else
  assign frames_ok   = '0;
  assign frames_lost = '0;
`endif
endmodule

// File: tb/tb_rx_frame_controller.sv
// tb_rx_frame_controller: randomized frame-level stimulus against a frame-granular
// reference model; a negedge monitor pops expected forwarded symbols from a scoreboard.
module tb_rx_frame_controller;
  localparam int FS = 63, VC = 2, ML = 3;
  logic clk = 1'b0, rst = 1'b1, sof_pulse = 1'b0, sym_valid = 1'b0;
  logic [1:0] sym_data = '0;
  logic out_valid, frame_start, frame_end, locked, sof_spurious;
  logic [1:0] out_data, state;
  logic [15:0] frames_ok, frames_lost;
  int vectors = 0, miscompares = 0;
  int ms = 0, mhits = 0, mmiss = 0, mok = 0, mlost = 0, exp_spur = 0, seen_spur = 0;
  logic [3:0] expq[$];
  logic [3:0] mon_e;

  always #5 clk = ~clk;

  rx_frame_controller dut (
    .clk(clk), .rst(rst), .sof_pulse(sof_pulse), .sym_valid(sym_valid), .sym_data(sym_data),
    .out_valid(out_valid), .out_data(out_data), .frame_start(frame_start), .frame_end(frame_end),
    .locked(locked), .state(state), .sof_spurious(sof_spurious),
    .frames_ok(frames_ok), .frames_lost(frames_lost)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_stat(input int v);
`ifdef RX_FRAME_STATS_EN
    return v > 65535 ? 65535 : v;
`else
    return 0;
`endif
  endfunction

  // frame-level model: one call per frame boundary event
  task automatic m_hit();
    case (ms)
      0: begin ms = 1; mhits = 0; end
      1: begin ms = (mhits == VC - 1) ? 2 : 1; mhits++; end
      default: begin ms = 2; mmiss = 0; mok++; end
    endcase
  endtask

  task automatic m_miss();
    case (ms)
      1: ms = 0;
      2: begin ms = 3; mmiss = 1; mlost++; end
      3: begin mmiss++; mlost++; if (mmiss >= ML) ms = 0; end
      default: ;
    endcase
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (sof_spurious) seen_spur++;
      if (out_valid) begin
        check("out_valid_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          mon_e = expq.pop_front();
          check("out_sym{data,start,end}", {out_data, frame_start, frame_end}, mon_e);
        end
      end else if (frame_start || frame_end)
        check("marker_without_valid", {frame_start, frame_end}, 0);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name);
    check({name, "_state"}, state, ms);
    check({name, "_locked"}, locked, ms >= 2);
  endtask

  task automatic ev_sof(input int w);
    repeat (w) tick();
    sof_pulse = 1'b1;
    sym_valid = 1'($urandom);
    sym_data  = 2'($urandom);
    tick();
    sof_pulse = 1'b0;
    sym_valid = 1'b0;
    m_hit();
    check_state("after_sof");
  endtask

  task automatic ev_timeout();
    repeat (2100) tick();
    m_miss();
    check_state("after_timeout");
  endtask

  task automatic payload(input int n, input int spur);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      sym_valid = 1'b1;
      sym_data  = 2'($urandom);
      if (i == spur && ms >= 2) begin
        sof_pulse = 1'b1;
        exp_spur++;
      end
      if (ms >= 2) expq.push_back({sym_data, 1'(i == 0), 1'(i == FS - 1)});
      tick();
      sym_valid = 1'b0;
      sof_pulse = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("reset_outputs", {out_valid, out_data, frame_start, frame_end, locked, state, sof_spurious}, 0);
    rst = 1'b0;
    // acquisition: three SOFs with 100-cycle gaps
    for (int k = 0; k < 3; k++) begin
      ev_sof(100);
      payload(FS, -1);
    end
    // one withheld SOF -> flywheel, then recovery
    ev_timeout();
    payload(FS, -1);
    ev_sof(50);
    check("frames_lost_after_flywheel", frames_lost, exp_stat(mlost));
    payload(FS, 30);
    // three withheld SOFs -> loss of lock
    ev_timeout();
    payload(FS, -1);
    ev_timeout();
    payload(FS, -1);
    ev_timeout();
    payload(FS, -1);
    // randomized frame sequence with occasional misses, boundary hits and spurious SOFs
    for (int f = 0; f < 40; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) ev_timeout();
      else ev_sof(r == 2 ? 2047 : $urandom_range(0, 100));
      payload(FS, $urandom_range(0, 3) == 0 ? $urandom_range(0, FS - 1) : -1);
    end
    // asynchronous reset in the middle of a locked payload
    while (ms != 2) begin
      ev_sof($urandom_range(0, 50));
      payload(FS, -1);
    end
    ev_sof(5);
    payload(30, -1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {out_valid, out_data, frame_start, frame_end, locked, state, sof_spurious}, 0);
    check("async_rst_frames_ok", frames_ok, 0);
    check("async_rst_frames_lost", frames_lost, 0);
    check("queue_at_reset", expq.size(), 1);
    expq.delete();
    tick();
    tick();
    rst = 1'b0;
    ms = 0; mhits = 0; mmiss = 0; mok = 0; mlost = 0;
    // VERIFY restart by a SOF inside the payload clears the hit count
    ev_sof(3);
    payload(FS, -1);
    ev_sof(20);
    payload(10, -1);
    sof_pulse = 1'b1;
    tick();
    sof_pulse = 1'b0;
    mhits = 0;
    check_state("verify_restart");
    payload(FS, -1);
    ev_sof(20);
    payload(FS, -1);
    ev_sof(20);
    payload(FS, -1);
    ev_sof(10);
    payload(FS, 30);
    ev_sof(2047);
    payload(FS, FS - 1);
    repeat (5) tick();
    check("queue_drained", expq.size(), 0);
    check("spurious_pulses", seen_spur, exp_spur);
    check("frames_ok", frames_ok, exp_stat(mok));
    check("frames_lost", frames_lost, exp_stat(mlost));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
